// File: rtl/constant_addition_sequencer.sv
// Round driver for the ASCON permutation p^a / p^b.
// Owns the permutation state register and the round counter, applies the
// round-constant addition (p_C) and feeds the result to the substitution layer.
// Optional feature: define PERM_ABORT_EN to add an abort_i input that drops a
// running permutation back to IDLE, keeping the partial state.

package ascon_pack;
   typedef struct packed {
      logic [63:0] x0;
      logic [63:0] x1;
      logic [63:0] x2;
      logic [63:0] x3;
      logic [63:0] x4;
   } type_state;
endpackage

module constant_addition_sequencer
   import ascon_pack::*;
#(
   parameter int unsigned NB_ROUNDS_A = 12,
   parameter int unsigned NB_ROUNDS_B = 6
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       mode_i,
`ifdef PERM_ABORT_EN
   input  logic       abort_i,
`endif
   input  type_state  state_i,
   output type_state  state_to_sbox_o,
   input  type_state  state_from_diff_i,
   output type_state  state_o,
   output logic [3:0] round_o,
   output logic       busy_o,
   output logic       done_o
);

   // The constant index always ends at 11, so a shorter permutation starts later.
   localparam logic [3:0] RoundStartA = 4'(12 - NB_ROUNDS_A);
   localparam logic [3:0] RoundStartB = 4'(12 - NB_ROUNDS_B);
   localparam logic [3:0] RoundLast   = 4'd11;

   typedef enum logic [0:0] {StIdle, StRun} fsm_e;

   fsm_e       fsm_q, fsm_d;
   type_state  state_q, state_d;
   logic [3:0] round_q, round_d;
   logic       done_q, done_d;
   logic [7:0] round_const;
   logic       abort;

`ifdef PERM_ABORT_EN
   assign abort = abort_i;
`else
   assign abort = 1'b0;
`endif

   // State, round counter and done pulse registers with synchronous reset.
   always_ff @(posedge clock_i) begin
      if (!resetb_i) begin
         fsm_q   <= StIdle;
         state_q <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: load on accepted start, one round per cycle while running.
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      round_d = round_q;
      done_d  = 1'b0;
      unique case (fsm_q)
         StIdle: begin
            if (start_i) begin
               state_d = state_i;
               round_d = mode_i ? RoundStartB : RoundStartA;
               fsm_d   = StRun;
            end
         end
         StRun: begin
            if (abort) begin
               // Partial state is kept for inspection; no completion pulse.
               fsm_d = StIdle;
            end else begin
               state_d = state_from_diff_i;
               if (round_q == RoundLast) begin
                  fsm_d  = StIdle;
                  done_d = 1'b1;
               end else begin
                  round_d = round_q + 4'd1;
               end
            end
         end
         default: fsm_d = StIdle;
      endcase
   end

   // Round constant addition into x2; valid in every state, including IDLE.
   always_comb begin
      round_const        = {4'hF - round_q, round_q};
      state_to_sbox_o    = state_q;
      state_to_sbox_o.x2 = state_q.x2 ^ {56'h0, round_const};
   end

   assign state_o = state_q;
   assign round_o = round_q;
   assign busy_o  = (fsm_q == StRun);
   assign done_o  = done_q;

endmodule

// File: tb/tb_constant_addition_sequencer.sv
// Self-checking bench for constant_addition_sequencer. p_S/p_L are stubbed as
// identity, so each round only XORs its constant into x2. Expected final states
// are queued at start and compared when done_o pulses.

module tb_constant_addition_sequencer;
   import ascon_pack::*;

   localparam int NbA = 12;
   localparam int NbB = 6;

   logic       clk = 1'b0;
   logic       resetb = 1'b0;
   logic       start = 1'b0;
   logic       mode = 1'b0;
   logic       abort = 1'b0;
   type_state  st_in = '0;
   type_state  to_sbox;
   type_state  from_diff;
   type_state  st_out;
   logic [3:0] round;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_errors = 0;
   int n_done = 0;

   type_state  exp_q[$];
   logic [7:0] rc_tab [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                               8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

   assign from_diff = to_sbox;

   constant_addition_sequencer #(
      .NB_ROUNDS_A(NbA),
      .NB_ROUNDS_B(NbB)
   ) u_dut (
      .clock_i          (clk),
      .resetb_i         (resetb),
      .start_i          (start),
      .mode_i           (mode),
`ifdef PERM_ABORT_EN
      .abort_i          (abort),
`endif
      .state_i          (st_in),
      .state_to_sbox_o  (to_sbox),
      .state_from_diff_i(from_diff),
      .state_o          (st_out),
      .round_o          (round),
      .busy_o           (busy),
      .done_o           (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: each done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (resetb && done) begin
         n_done++;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_done", 320'(1), 320'(0));
         end else begin
            check_eq("final_state", st_out, exp_q.pop_front());
         end
      end
   end

   function automatic type_state model(input logic m, input type_state st, input int upto);
      type_state  e = st;
      int         n = m ? NbB : NbA;
      for (int r = 12 - n; r < upto; r++) e.x2 ^= {56'h0, rc_tab[r]};
      return e;
   endfunction

   task automatic start_perm(input logic m, input type_state st);
      start = 1'b1;
      mode  = m;
      st_in = st;
      exp_q.push_back(model(m, st, 12));
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int cnt = 0;
      while (!done && cnt < bound) begin
         tick();
         cnt++;
      end
      check_eq("done_reached", 320'(done), 320'(1));
   endtask

   // Full run with per-cycle checks of busy, round index and the first constant.
   task automatic run_perm(input logic m, input type_state st);
      int n = m ? NbB : NbA;
      start_perm(m, st);
      check_eq("first_sbox_x2", 320'(to_sbox.x2), 320'(st.x2 ^ {56'h0, rc_tab[12 - n]}));
      for (int i = 0; i < n; i++) begin
         check_eq("busy_run", 320'(busy), 320'(1));
         check_eq("round_idx", 320'(round), 320'(12 - n + i));
         check_eq("no_early_done", 320'(done), 320'(0));
         tick();
      end
      check_eq("done_pulse", 320'(done), 320'(1));
      check_eq("busy_at_done", 320'(busy), 320'(0));
   endtask

   initial begin
      type_state iv;
      type_state st_a;
      type_state st_b;
      type_state fin;

      iv.x0 = 64'h80400c0600000000;
      iv.x1 = 64'h0001020304050607;
      iv.x2 = 64'hbe263d4d7aecaa0f;
      iv.x3 = 64'h08090a0b0c0d0e0f;
      iv.x4 = 64'h0706050403020100;

      // Reset held two cycles, then released.
      resetb = 1'b0;
      tick();
      tick();
      resetb = 1'b1;
      check_eq("rst_state", st_out, 320'(0));
      check_eq("rst_round", 320'(round), 320'(0));
      check_eq("rst_busy", 320'(busy), 320'(0));
      check_eq("rst_done", 320'(done), 320'(0));
      check_eq("idle_sbox_x2", 320'(to_sbox.x2), 320'(64'hf0));
      tick();

      // p^a on an IV-like state: 12 constants cancel, x2 returns to its input.
      run_perm(1'b0, iv);
      check_eq("pa_x2_const", 320'(st_out.x2), 320'(64'hbe263d4d7aecaa0f));
      fin = st_out;
      tick();
      tick();
      check_eq("pa_hold", st_out, fin);
      check_eq("done_one_cycle", 320'(done), 320'(0));

      // p^b with x2 = 0: final x2 = 0x11.
      st_a = iv;
      st_a.x2 = 64'h0;
      run_perm(1'b1, st_a);
      check_eq("pb_x2_const", 320'(st_out.x2), 320'(64'h11));
      tick();

      // Start mid-run is ignored; start in the done cycle is accepted.
      st_a.x2 = 64'h0123456789abcdef;
      st_b = iv;
      st_b.x4 = 64'hdeadbeefcafef00d;
      start_perm(1'b1, st_a);
      tick();
      tick();
      start = 1'b1;
      mode  = 1'b0;
      st_in = '1;
      tick();
      start = 1'b0;
      check_eq("ignored_round", 320'(round), 320'(9));
      check_eq("ignored_busy", 320'(busy), 320'(1));
      wait_done(20);
      start_perm(1'b1, st_b);
      check_eq("b2b_busy", 320'(busy), 320'(1));
      check_eq("b2b_round", 320'(round), 320'(6));
      check_eq("b2b_done_low", 320'(done), 320'(0));
      wait_done(20);
      tick();

      // Reset during round 5 clears everything without a done pulse.
      start_perm(1'b0, iv);
      for (int i = 0; i < 5; i++) tick();
      check_eq("pre_rst_round", 320'(round), 320'(5));
      resetb = 1'b0;
      exp_q.delete();
      tick();
      check_eq("midrst_busy", 320'(busy), 320'(0));
      check_eq("midrst_state", st_out, 320'(0));
      check_eq("midrst_done", 320'(done), 320'(0));
      resetb = 1'b1;
      for (int i = 0; i < 15; i++) tick();

`ifdef PERM_ABORT_EN
      // Abort during round 5 keeps the state after rounds 0..4.
      start_perm(1'b0, iv);
      for (int i = 0; i < 5; i++) tick();
      abort = 1'b1;
      exp_q.delete();
      tick();
      abort = 1'b0;
      check_eq("abort_busy", 320'(busy), 320'(0));
      check_eq("abort_state", st_out, model(1'b0, iv, 5));
      for (int i = 0; i < 15; i++) tick();
`endif

      check_eq("done_count", 320'(n_done), 320'(4));
      check_eq("queue_empty", 320'(exp_q.size()), 320'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
